demux1to2_pipe: RTL
===================

# demux1to2_pipe

Registered 1-to-2 stream demultiplexer: accepts one valid/ready stream of n-bit words, each tagged with a 1-bit destination select, and steers it into one of two independent output channels. Each channel buffers words in its own DEPTH-entry FIFO, so backpressure on one destination does not block traffic to the other. It sits wherever one producer feeds two consumers in the core, for example a result bus split toward two write-back or issue paths. It is the counterpart of the 2:1 select mux.

## Interface
- n, 32, data width in bits.
- DEPTH, 2, entries per output FIFO; power of two, ≥2.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  word is accepted at this edge if in_valid is also high.
- in_sel  in  1  destination: 0 → channel 0, 1 → channel 1; sampled only when in_valid=1.
- in_data  in  n  payload.
- out0_valid / out1_valid  out  1  channel FIFO non-empty.
- out0_ready / out1_ready  in  1  consumer pops the head at this edge.
- out0_data / out1_data  out  n  channel FIFO head.
- out0_count / out1_count  out  $clog2(DEPTH+1)  channel occupancy, 0..DEPTH.

## Operation
- Two identical channel FIFOs. Each has a storage array, a rd_ptr and wr_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH, and a count register.
- in_ready = ~full[in_sel], where full[k] = (count_k == DEPTH). in_ready is combinational from in_sel and current counts only.
- in_ready does not depend on in_valid or on any outX_ready. There is no pass-through when the FIFO is full.
- When in_valid is low, the value of in_ready is don't-care.
- push_k = in_valid & in_ready & (in_sel == k). At most one channel is pushed per cycle.
- pop_k = outk_valid & outk_ready. A pop request on an empty channel is ignored: no pointer or count change.
- On push_k: mem_k[wr_ptr_k] ← in_data, and wr_ptr_k increments.
- On pop_k: rd_ptr_k increments.
- count_k update:
  - push only: +1.
  - pop only: −1.
  - both: unchanged.
- outk_valid = (count_k != 0). outk_data = mem_k[rd_ptr_k].
- outk_data is combinational from registered state only, with no path from any input port.
- Per-channel ordering is FIFO. There is no ordering relation between the two channels.
- Reset (asynchronous, reset_n=0) clears the following immediately, regardless of clk:
  - all pointers and counts → 0;
  - all storage → 0;
  - therefore out0_valid=out1_valid=0, out0_data=out1_data=0, and out0_count=out1_count=0.
- Words in flight at reset are discarded. Outputs stay at reset values until the first push after reset_n deasserts.

## Timing
- Latency: a word accepted at edge t appears on outk_data with outk_valid=1 immediately after edge t, i.e. during cycle t+1, provided it is the FIFO head.
- Throughput: one word per cycle into either channel, as long as the selected FIFO is not full.
- A full channel with outk_ready=1 in the same cycle still reports in_ready=0 for that channel. It accepts again the cycle after the pop.
- A full channel does not stall traffic to the other channel: in_ready follows in_sel.
- Simultaneous push and pop on the same channel:
  - on a non-empty, non-full FIFO, both happen and count is unchanged;
  - on an empty FIFO, only the push happens, and the word is visible next cycle.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Data integrity must hold across an arbitrary number of wraps.
- Producer contract: in_data and in_sel are held stable while in_valid=1 and in_ready=0. The block itself does not register anything in that case.

## Test plan
- Reset values: assert reset_n=0 mid-cycle, with no clk edge → outputs are 0 and counts are 0 immediately. After release, in_ready=1 for both in_sel values.
- Steering and latency: push 0xA5A5_0001 (sel 0), then 0x5A5A_0002 (sel 1), back-to-back → in the cycle after each edge, the matching out_valid=1 with that data. The other channel is unaffected.
- Full/backpressure: hold out0_ready=0 and push 3 words with sel 0 (DEPTH=2) → out0_count=2 and in_ready=0 on the third. With in_sel=1 in the same cycle, in_ready=1 and the word is accepted into channel 1.
- Full with simultaneous pop: channel 0 full, out0_ready=1, in_valid=1, sel 0 → in_ready=0 that cycle and count drops to 1. Next cycle the word is accepted and count returns to 2.
- Wrap and ordering: stream 0x0000_0000..0x0000_0013 (20 words) to channel 1 with random out1_ready stalls → output order is identical, with no loss or duplication. Pop on empty is ignored.
- Reset mid-operation: both FIFOs holding 2 words, then reset_n pulsed low → counts become 0, valids become 0, data becomes 0. After release, stale words never reappear.

Source files
------------

// File: rtl/demux1to2_pipe.sv
// Registered 1-to-2 stream demultiplexer: one valid/ready input stream steered by
// in_sel into two independent DEPTH-entry FIFO channels with their own backpressure.
module demux1to2_pipe #(
  parameter int n     = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sel,
  input  logic [n-1:0]                 in_data,
  output logic                         out0_valid,
  input  logic                         out0_ready,
  output logic [n-1:0]                 out0_data,
  output logic [$clog2(DEPTH+1)-1:0]   out0_count,
  output logic                         out1_valid,
  input  logic                         out1_ready,
  output logic [n-1:0]                 out1_data,
  output logic [$clog2(DEPTH+1)-1:0]   out1_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]    full;
  logic [1:0]    valid;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    rdy;
  logic [n-1:0]  head [2];
  logic [CW-1:0] cnt  [2];

  // Acceptance looks only at the selected channel's occupancy; a pop in the
  // same cycle does not free a slot until the following cycle.
  assign in_ready = ~full[in_sel];
  assign rdy      = {out1_ready, out0_ready};

  for (genvar k = 0; k < 2; k++) begin : g_ch
    logic [n-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    assign full[k]  = (count == CW'(DEPTH));
    assign valid[k] = (count != '0);
    assign push[k]  = in_valid & in_ready & (in_sel == 1'(k));
    assign pop[k]   = valid[k] & rdy[k];
    assign head[k]  = mem[rd_ptr];
    assign cnt[k]   = count;

    // NOTE: storage is cleared by reset as well so a freshly reset channel
    // presents zero data rather than stale words.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
        // NOTE: non-blocking assignments keep every register update based on
        // the pre-edge values, so pointer, count and storage stay coherent.
        if (push[k]) begin
          mem[wr_ptr] <= in_data;
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (pop[k]) rd_ptr <= rd_ptr + PW'(1);
        case ({push[k], pop[k]})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  assign out0_valid = valid[0];
  assign out1_valid = valid[1];
  assign out0_data  = head[0];
  assign out1_data  = head[1];
  assign out0_count = cnt[0];
  assign out1_count = cnt[1];

endmodule
